// File: rtl/evaluador_rama_serie.sv
// Serial RV32I branch evaluator: scans operand bits MSB first,
// one pair per cycle, and reports the branch outcome on Y[0].
module evaluador_rama_serie #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [2:0]       funct3,
  output logic             ocupado,
  output logic             listo,
  output logic [31:0]      Y
);

  localparam int CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  localparam logic [1:0] REPOSO  = 2'd0;
  localparam logic [1:0] COMPARA = 2'd1;
  localparam logic [1:0] FIN     = 2'd2;

  logic [1:0]       estado;
  logic [ANCHO-1:0] ra;
  logic [ANCHO-1:0] rb;
  logic [2:0]       rf;
  logic [CW-1:0]    cnt;
  logic             decidido;
  logic             mayor_a;
  logic             y_q;

  logic bit_a;
  logic bit_b;
  logic con_signo;
  logic es_msb;
  logic dec_n;
  logic may_n;
  logic igual;
  logic menor;
  logic cond;

  // Next decision flags for the current bit pair and the branch outcome
  always_comb begin
    bit_a     = ra[cnt];
    bit_b     = rb[cnt];
    con_signo = (rf[2:1] == 2'b10);
    es_msb    = (cnt == CW'(ANCHO - 1));
    dec_n     = decidido;
    may_n     = mayor_a;
    if (!decidido && (bit_a ^ bit_b)) begin
      dec_n = 1'b1;
      // a sign bit of 1 makes a the smaller operand
      may_n = bit_a ^ (con_signo && es_msb);
    end
    igual = !dec_n;
    menor = dec_n && !may_n;
    case (rf)
      3'b000:  cond = igual;
      3'b001:  cond = !igual;
      3'b100:  cond = menor;
      3'b101:  cond = !menor;
      3'b110:  cond = menor;
      3'b111:  cond = !menor;
      default: cond = 1'b0;
    endcase
  end

  // Control FSM, operand latch, bit scan and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado   <= REPOSO;
      ra       <= '0;
      rb       <= '0;
      rf       <= '0;
      cnt      <= '0;
      decidido <= 1'b0;
      mayor_a  <= 1'b0;
      y_q      <= 1'b0;
    end else begin
      case (estado)
        // FIN's exit edge doubles as an idle sampling point so that
        // back-to-back requests get one result every ANCHO+1 cycles
        REPOSO, FIN: begin
          if (inicio) begin
            ra       <= a;
            rb       <= b;
            rf       <= funct3;
            cnt      <= CW'(ANCHO - 1);
            decidido <= 1'b0;
            mayor_a  <= 1'b0;
            estado   <= COMPARA;
          end else begin
            estado   <= REPOSO;
          end
        end
        COMPARA: begin
          decidido <= dec_n;
          mayor_a  <= may_n;
          if (cnt == '0) begin
            y_q    <= cond;
            estado <= FIN;
          end else begin
            cnt    <= cnt - 1'b1;
          end
        end
        default: estado <= REPOSO;
      endcase
    end
  end

  assign ocupado = (estado != REPOSO);
  assign listo   = (estado == FIN);
  assign Y       = {31'b0, y_q};

endmodule

// File: doc/evaluador_rama_serie.md
EVALUADOR_RAMA_SERIE -- requirements
Module: evaluador_rama_serie

Interface
REQ-001 Parameter ANCHO, default 32, operand width in bits; legal values 2..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 inicio  input  1  start request; sampled only while idle.
REQ-005 a  input  ANCHO  first operand (rs1 value).
REQ-006 b  input  ANCHO  second operand (rs2 value).
REQ-007 funct3  input  3  RV32I branch condition code.
REQ-008 ocupado  output  1  high while an evaluation is in progress.
REQ-009 listo  output  1  one-cycle pulse marking a valid result.
REQ-010 Y  output  32  result: 32'd1 if the condition holds, 32'd0 otherwise.

Function
REQ-011 The block SHALL use three states: REPOSO (idle), COMPARA (bit scan) and FIN (result).
REQ-012 In REPOSO, inicio=1 at an edge SHALL latch a, b and funct3, load the bit counter with ANCHO-1, and enter COMPARA.
REQ-013 In REPOSO, inicio=0 SHALL hold the state; inicio in any other state SHALL be ignored, with no queuing.
REQ-014 COMPARA SHALL examine one latched bit pair per cycle, MSB first, for exactly ANCHO cycles; there is no early exit.
REQ-015 The first differing bit pair SHALL set the flag decidido and record mayor_a (a bit = 1); later bit pairs SHALL NOT alter these flags.
REQ-016 For signed codes (100, 101), a difference at the MSB SHALL be interpreted inverted: a MSB = 1 means a < b.
REQ-017 Derived relations: igual = !decidido; menor = decidido && !mayor_a (after the signed MSB inversion where it applies).
REQ-018 Condition per funct3: 000 igual; 001 !igual; 100 signed menor; 101 !signed menor; 110 unsigned menor; 111 !unsigned menor.
REQ-019 funct3 010 or 011 SHALL produce Y = 0 with the normal latency.
REQ-020 At the edge that processes bit 0, the block SHALL register Y and move to FIN.
REQ-021 In FIN, listo SHALL be 1 for exactly one cycle; the next edge SHALL return to REPOSO.
REQ-022 ocupado SHALL be 1 in COMPARA and FIN, and 0 in REPOSO.
REQ-023 Latency: with inicio accepted at edge 0, Y is valid and listo = 1 after edge ANCHO; a new inicio can be accepted at edge ANCHO+1 at the earliest.
REQ-024 Y SHALL hold its value from FIN until the next result is registered.
REQ-025 Changes on a, b or funct3 after acceptance SHALL NOT affect the running evaluation.
REQ-026 Y bits [31:1] SHALL always be 0.

Reset
REQ-027 rst = 1 SHALL immediately, without waiting for clk, force state REPOSO, ocupado = 0, listo = 0, Y = 0, clear decidido, mayor_a and the counter, and clear the latched operands.
REQ-028 Reset asserted during COMPARA or FIN SHALL abort the evaluation with no listo pulse.
REQ-029 After rst deasserts, the first rising edge with inicio = 1 SHALL be accepted normally.

Verification
REQ-030 Scenario: a = 112, b = 112, funct3 = 000 -> listo after 32 edges, Y = 1; repeated with funct3 = 001 -> Y = 0.
REQ-031 Scenario: a = -5 (0xFFFFFFFB), b = 3, funct3 = 100 -> Y = 1; same operands with funct3 = 110 -> Y = 0.
REQ-032 Scenario: a = 0x80000000, b = 0x7FFFFFFF, funct3 = 101 -> Y = 0; funct3 = 111 -> Y = 1.
REQ-033 Scenario: inicio held high continuously with random operands -> one result every ANCHO+1 cycles; ocupado and listo timing match REQ-023.
REQ-034 Scenario: rst pulsed mid-COMPARA (cycle 10) -> outputs zero immediately, no listo; the next inicio with a = 1, b = 2, funct3 = 110 -> Y = 1.
REQ-035 Scenario: 200 random operand pairs in -1000..1000 across all six branch codes -> Y matches a software reference model; operands changed during COMPARA do not alter Y.
